// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, programmable H/V counters,
// blank/sync decode, blanked colour register, vblank interrupt and frame counter.
module video_timing_gen #(
   parameter int CLK_DIV      = 8,
   parameter int HW           = 9,
   parameter int VW           = 9,
   parameter int RGB_W        = 12,
   parameter int H_TOTAL      = 384,
   parameter int H_ACT_START  = 16,
   parameter int H_ACT_W      = 256,
   parameter int H_SYNC_START = 296,
   parameter int H_SYNC_W     = 32,
   parameter int V_TOTAL      = 263,
   parameter int V_ACT_START  = 16,
   parameter int V_ACT_H      = 192,
   parameter int V_SYNC_START = 236,
   parameter int V_SYNC_W     = 7
) (
   input  logic             MCLK,
   input  logic             RESET,
   input  logic             FLIP,
   output logic             PCLK,
   output logic [HW-1:0]    HPOS,
   output logic [VW-1:0]    VPOS,
   input  logic [RGB_W-1:0] iRGB,
   output logic [RGB_W-1:0] oRGB,
   output logic             HBLK,
   output logic             VBLK,
   output logic             HSYN,
   output logic             VSYN,
   output logic             VINT,
   output logic [7:0]       FRAME
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_INT_ROW = VW'(V_ACT_START + V_ACT_H - 1);

   // Window bounds are one bit wider so an end bound equal to 2^HW still fits.
   localparam logic [HW:0] H_A0 = (HW+1)'(H_ACT_START);
   localparam logic [HW:0] H_A1 = (HW+1)'(H_ACT_START + H_ACT_W);
   localparam logic [HW:0] H_S0 = (HW+1)'(H_SYNC_START);
   localparam logic [HW:0] H_S1 = (HW+1)'(H_SYNC_START + H_SYNC_W);
   localparam logic [VW:0] V_A0 = (VW+1)'(V_ACT_START);
   localparam logic [VW:0] V_A1 = (VW+1)'(V_ACT_START + V_ACT_H);
   localparam logic [VW:0] V_S0 = (VW+1)'(V_SYNC_START);
   localparam logic [VW:0] V_S1 = (VW+1)'(V_SYNC_START + V_SYNC_W);

   localparam logic [HW-1:0] H_OFS  = HW'(H_ACT_START);
   localparam logic [VW-1:0] V_OFS  = VW'(V_ACT_START);
   localparam logic [HW-1:0] H_FLIP = HW'(H_ACT_START + H_ACT_W - 1);
   localparam logic [VW-1:0] V_FLIP = VW'(V_ACT_START + V_ACT_H - 1);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("video_timing_gen: CLK_DIV must be at least 2");
   end
   if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter width");
   end
   if (H_ACT_START + H_ACT_W > H_TOTAL || H_SYNC_START + H_SYNC_W > H_TOTAL) begin : g_bad_h
      $error("video_timing_gen: horizontal window outside H_TOTAL");
   end
   if (V_ACT_START + V_ACT_H > V_TOTAL || V_SYNC_START + V_SYNC_W > V_TOTAL) begin : g_bad_v
      $error("video_timing_gen: vertical window outside V_TOTAL");
   end

   logic [DW-1:0] div;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [HW:0]   hcnt_x;
   logic [VW:0]   vcnt_x;
   logic          h_act, v_act, h_syn, v_syn, h_end, v_end, vint_hit;

   assign hcnt_x   = {1'b0, hcnt};
   assign vcnt_x   = {1'b0, vcnt};
   assign h_act    = (hcnt_x >= H_A0) && (hcnt_x < H_A1);
   assign v_act    = (vcnt_x >= V_A0) && (vcnt_x < V_A1);
   assign h_syn    = (hcnt_x >= H_S0) && (hcnt_x < H_S1);
   assign v_syn    = (vcnt_x >= V_S0) && (vcnt_x < V_S1);
   assign h_end    = (hcnt == H_LAST);
   assign v_end    = (vcnt == V_LAST);
   assign vint_hit = PCLK && h_end && (vcnt == V_INT_ROW);

   // Flipped positions are only meaningful inside the active window.
   assign HPOS = FLIP ? (H_FLIP - hcnt) : (hcnt - H_OFS);
   assign VPOS = FLIP ? (V_FLIP - vcnt) : (vcnt - V_OFS);

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         div   <= '0;
         hcnt  <= '0;
         vcnt  <= '0;
         PCLK  <= 1'b0;
         VINT  <= 1'b0;
         FRAME <= 8'd0;
         oRGB  <= '0;
         HBLK  <= 1'b1;
         VBLK  <= 1'b1;
         HSYN  <= 1'b1;
         VSYN  <= 1'b1;
      end else begin
         div  <= (div == DIV_LAST) ? '0 : div + 1'b1;
         PCLK <= (div == DIV_LAST);
         VINT <= vint_hit;
         if (vint_hit) FRAME <= FRAME + 8'd1;
         if (PCLK) begin
            // Video registers decode the pre-increment count, so they trail HPOS/VPOS by one pixel.
            HBLK <= !h_act;
            VBLK <= !v_act;
            HSYN <= !h_syn;
            VSYN <= !v_syn;
            oRGB <= (h_act && v_act) ? iRGB : '0;
            if (h_end) begin
               hcnt <= '0;
               vcnt <= v_end ? '0 : vcnt + 1'b1;
            end else begin
               hcnt <= hcnt + 1'b1;
            end
         end
      end
   end

endmodule
